// File: rtl/doa_result_buffer.sv
// Ping-pong frame buffer holding the dominant eigenpair of each DOA channel result.
// Read latency 1 cycle; input is never stalled, full frames are dropped at completion.
module doa_result_buffer #(
  parameter int DIN_WIDTH  = 16,
  parameter int DIN_POINT  = 10,
  parameter int VECTOR_LEN = 64,
  parameter int ADDR_WIDTH = $clog2(VECTOR_LEN)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic signed [DIN_WIDTH-1:0]  lamb1,
  input  logic signed [DIN_WIDTH-1:0]  lamb2,
  input  logic signed [DIN_WIDTH-1:0]  eigen1_y,
  input  logic signed [DIN_WIDTH-1:0]  eigen2_y,
  input  logic signed [DIN_WIDTH-1:0]  eigen_x,
  input  logic                         din_valid,
  input  logic                         din_error,
  output logic                         frame_ready,
  output logic                         frame_error,
  input  logic [ADDR_WIDTH-1:0]        rd_addr,
  input  logic                         rd_en,
  input  logic                         read_done,
  output logic signed [DIN_WIDTH-1:0]  dout_lamb,
  output logic signed [DIN_WIDTH-1:0]  dout_y,
  output logic signed [DIN_WIDTH-1:0]  dout_x,
  output logic                         dout_valid,
  output logic                         overflow,
  output logic [15:0]                  drop_count
);

  localparam int WORD_W = 3 * DIN_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(VECTOR_LEN - 1);

  if ((VECTOR_LEN < 2) || ((VECTOR_LEN & (VECTOR_LEN - 1)) != 0) ||
      (DIN_POINT < 0) || (DIN_POINT >= DIN_WIDTH)) begin : g_bad_params
    $error("doa_result_buffer: illegal parameter set");
  end

  logic [WORD_W-1:0] mem [2*VECTOR_LEN];

  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic                  wr_bank_q, wr_bank_d;
  logic                  rd_bank_q, rd_bank_d;
  logic [1:0]            bank_full_q, bank_full_d;
  logic [1:0]            bank_err_q, bank_err_d;
  logic                  acc_err_q, acc_err_d;
  logic                  overflow_q, overflow_d;
  logic [15:0]           drop_count_q, drop_count_d;
  logic                  dout_valid_q;
  logic signed [DIN_WIDTH-1:0] dout_lamb_q, dout_y_q, dout_x_q;

  logic [WORD_W-1:0] sel_word;
  logic [WORD_W-1:0] rd_word;
  logic              release_rd;
  logic              wr_bank_free;
  logic              wr_en;
  logic              frame_done;
  logic              rd_fire;

  always_comb begin
    sel_word = {lamb2, eigen2_y, eigen_x};
    if (lamb1 >= lamb2) begin
      sel_word = {lamb1, eigen1_y, eigen_x};
    end
  end

  assign frame_ready = bank_full_q[rd_bank_q];
  assign frame_error = bank_err_q[rd_bank_q];
  assign release_rd  = read_done && frame_ready;
  assign rd_fire     = rd_en && frame_ready;
  assign frame_done  = din_valid && (wr_addr_q == LAST_ADDR);

  // A held frame is never overwritten: the target bank must be empty or be
  // released by the reader on this very edge.
  assign wr_bank_free = !bank_full_q[wr_bank_q] || (release_rd && (rd_bank_q == wr_bank_q));
  assign wr_en        = din_valid && wr_bank_free && !rst;

  always_comb begin
    wr_addr_d    = wr_addr_q;
    wr_bank_d    = wr_bank_q;
    rd_bank_d    = rd_bank_q;
    bank_full_d  = bank_full_q;
    bank_err_d   = bank_err_q;
    acc_err_d    = acc_err_q;
    overflow_d   = 1'b0;
    drop_count_d = drop_count_q;

    if (release_rd) begin
      bank_full_d[rd_bank_q] = 1'b0;
      rd_bank_d              = ~rd_bank_q;
    end

    if (din_valid) begin
      wr_addr_d = wr_addr_q + 1'b1;
      acc_err_d = acc_err_q | din_error;
      if (frame_done) begin
        acc_err_d = 1'b0;
        if (wr_bank_free) begin
          bank_full_d[wr_bank_q] = 1'b1;
          bank_err_d[wr_bank_q]  = acc_err_q | din_error;
          wr_bank_d              = ~wr_bank_q;
        end else begin
          overflow_d = 1'b1;
          if (drop_count_q != 16'hFFFF) begin
            drop_count_d = drop_count_q + 16'd1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_addr_q    <= '0;
      wr_bank_q    <= 1'b0;
      rd_bank_q    <= 1'b0;
      bank_full_q  <= '0;
      bank_err_q   <= '0;
      acc_err_q    <= 1'b0;
      overflow_q   <= 1'b0;
      drop_count_q <= '0;
    end else begin
      wr_addr_q    <= wr_addr_d;
      wr_bank_q    <= wr_bank_d;
      rd_bank_q    <= rd_bank_d;
      bank_full_q  <= bank_full_d;
      bank_err_q   <= bank_err_d;
      acc_err_q    <= acc_err_d;
      overflow_q   <= overflow_d;
      drop_count_q <= drop_count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[{wr_bank_q, wr_addr_q}] <= sel_word;
    end
  end

  assign rd_word = mem[{rd_bank_q, rd_addr}];

  always_ff @(posedge clk) begin
    if (rst) begin
      dout_valid_q <= 1'b0;
      dout_lamb_q  <= '0;
      dout_y_q     <= '0;
      dout_x_q     <= '0;
    end else begin
      dout_valid_q <= rd_fire;
      if (rd_fire) begin
        dout_lamb_q <= rd_word[WORD_W-1 -: DIN_WIDTH];
        dout_y_q    <= rd_word[2*DIN_WIDTH-1 -: DIN_WIDTH];
        dout_x_q    <= rd_word[DIN_WIDTH-1:0];
      end
    end
  end

  assign dout_lamb  = dout_lamb_q;
  assign dout_y     = dout_y_q;
  assign dout_x     = dout_x_q;
  assign dout_valid = dout_valid_q;
  assign overflow   = overflow_q;
  assign drop_count = drop_count_q;

endmodule

// File: tb/tb_doa_result_buffer.sv
// Directed bench for doa_result_buffer: capture, dominant selection, ping-pong, drops, errors, reset.
module tb_doa_result_buffer;

  logic clk = 1'b0;
  logic rst;
  logic signed [15:0] lamb1, lamb2, eigen1_y, eigen2_y, eigen_x;
  logic din_valid, din_error;
  logic frame_ready, frame_error;
  logic [5:0] rd_addr;
  logic rd_en, read_done;
  logic signed [15:0] dout_lamb, dout_y, dout_x;
  logic dout_valid, overflow;
  logic [15:0] drop_count;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  doa_result_buffer #(.DIN_WIDTH(16), .DIN_POINT(10), .VECTOR_LEN(64)) dut (
    .clk(clk), .rst(rst),
    .lamb1(lamb1), .lamb2(lamb2), .eigen1_y(eigen1_y), .eigen2_y(eigen2_y), .eigen_x(eigen_x),
    .din_valid(din_valid), .din_error(din_error),
    .frame_ready(frame_ready), .frame_error(frame_error),
    .rd_addr(rd_addr), .rd_en(rd_en), .read_done(read_done),
    .dout_lamb(dout_lamb), .dout_y(dout_y), .dout_x(dout_x), .dout_valid(dout_valid),
    .overflow(overflow), .drop_count(drop_count)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_range(input int first, input int last, input int tag, input int err_ch);
    for (int i = first; i <= last; i++) begin
      lamb1     = 16'(i);
      lamb2     = 16'sd0;
      eigen1_y  = 16'(100 + i);
      eigen2_y  = 16'sh7777;
      eigen_x   = 16'(tag);
      din_error = (i == err_ch);
      din_valid = 1'b1;
      tick();
    end
    din_valid = 1'b0;
    din_error = 1'b0;
  endtask

  task automatic read_addr(input int addr);
    rd_addr = 6'(addr);
    rd_en   = 1'b1;
    tick();
    rd_en   = 1'b0;
  endtask

  task automatic pulse_done();
    read_done = 1'b1;
    tick();
    read_done = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    vectors++;
    if ({frame_ready, frame_error, dout_valid, overflow} !== 4'b0000 || drop_count !== 16'd0 ||
        dout_lamb !== 16'sd0) begin
      miscompares++;
      $display("FAIL reset: rdy/err/vld/ovf=%b drop=%0d lamb=%0d, required 0000 0 0",
               {frame_ready, frame_error, dout_valid, overflow}, drop_count, dout_lamb);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic_frame();
    write_range(0, 62, 7, -1);
    vectors++;
    if (frame_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL early_ready: frame_ready=%b after 63 writes, required 0", frame_ready);
    end
    write_range(63, 63, 7, -1);
    vectors++;
    if (frame_ready !== 1'b1 || frame_error !== 1'b0) begin
      miscompares++;
      $display("FAIL frame_ready_rise: ready=%b err=%b, required 1 0", frame_ready, frame_error);
    end
    read_addr(5);
    vectors++;
    if (dout_valid !== 1'b1 || dout_lamb !== 16'sd5 || dout_y !== 16'sd105 || dout_x !== 16'sd7) begin
      miscompares++;
      $display("FAIL read5: vld=%b lamb=%0d y=%0d x=%0d, required 1 5 105 7",
               dout_valid, dout_lamb, dout_y, dout_x);
    end
    tick();
    vectors++;
    if (dout_valid !== 1'b0 || dout_lamb !== 16'sd5) begin
      miscompares++;
      $display("FAIL valid_drop: vld=%b lamb=%0d, required 0 5", dout_valid, dout_lamb);
    end
    read_addr(63);
    vectors++;
    if (dout_valid !== 1'b1 || dout_lamb !== 16'sd63 || dout_y !== 16'sd163) begin
      miscompares++;
      $display("FAIL read63: vld=%b lamb=%0d y=%0d, required 1 63 163", dout_valid, dout_lamb, dout_y);
    end
    pulse_done();
    vectors++;
    if (frame_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL release: frame_ready=%b, required 0", frame_ready);
    end
    read_addr(9);
    vectors++;
    if (dout_valid !== 1'b0 || dout_lamb !== 16'sd63) begin
      miscompares++;
      $display("FAIL read_not_ready: vld=%b lamb=%0d, required 0 63", dout_valid, dout_lamb);
    end
  endtask

  task automatic test_dominant();
    din_valid = 1'b1;
    lamb1 = -16'sd3; lamb2 = 16'sd2; eigen1_y = 16'sh1111; eigen2_y = 16'sh1234; eigen_x = 16'sh0055;
    tick();
    lamb1 = 16'sd9; lamb2 = 16'sd9; eigen1_y = 16'sh0AAA; eigen2_y = 16'sh0BBB; eigen_x = 16'sh0066;
    tick();
    lamb1 = -16'sd5; lamb2 = -16'sd4; eigen1_y = 16'sh0101; eigen2_y = 16'sh0202; eigen_x = 16'sh0077;
    tick();
    write_range(3, 63, 8, -1);
    read_addr(0);
    vectors++;
    if (dout_lamb !== 16'sd2 || dout_y !== 16'sh1234 || dout_x !== 16'sh0055) begin
      miscompares++;
      $display("FAIL dom_lamb2: lamb=%0d y=%h x=%h, required 2 1234 0055", dout_lamb, dout_y, dout_x);
    end
    read_addr(1);
    vectors++;
    if (dout_lamb !== 16'sd9 || dout_y !== 16'sh0AAA || dout_x !== 16'sh0066) begin
      miscompares++;
      $display("FAIL dom_tie: lamb=%0d y=%h x=%h, required 9 0aaa 0066", dout_lamb, dout_y, dout_x);
    end
    read_addr(2);
    vectors++;
    if (dout_lamb !== -16'sd4 || dout_y !== 16'sh0202) begin
      miscompares++;
      $display("FAIL dom_neg: lamb=%0d y=%h, required -4 0202", dout_lamb, dout_y);
    end
    pulse_done();
  endtask

  task automatic test_back_to_back();
    write_range(0, 63, 16'h0A, -1);
    write_range(0, 63, 16'h0B, -1);
    read_addr(3);
    vectors++;
    if (dout_x !== 16'sh000A || dout_lamb !== 16'sd3) begin
      miscompares++;
      $display("FAIL b2b_frameA: x=%h lamb=%0d, required 000a 3", dout_x, dout_lamb);
    end
    pulse_done();
    read_addr(3);
    vectors++;
    if (frame_ready !== 1'b1 || dout_x !== 16'sh000B || dout_y !== 16'sd103) begin
      miscompares++;
      $display("FAIL b2b_frameB: ready=%b x=%h y=%0d, required 1 000b 103", frame_ready, dout_x, dout_y);
    end
    pulse_done();
    vectors++;
    if (frame_ready !== 1'b0 || drop_count !== 16'd0) begin
      miscompares++;
      $display("FAIL b2b_empty: ready=%b drop=%0d, required 0 0", frame_ready, drop_count);
    end
  endtask

  task automatic test_overflow();
    write_range(0, 63, 16'h21, -1);
    write_range(0, 63, 16'h22, -1);
    vectors++;
    if (overflow !== 1'b0) begin
      miscompares++;
      $display("FAIL ovf_false: overflow=%b after two frames, required 0", overflow);
    end
    write_range(0, 63, 16'h23, -1);
    vectors++;
    if (overflow !== 1'b1 || drop_count !== 16'd1) begin
      miscompares++;
      $display("FAIL ovf_pulse: overflow=%b drop=%0d, required 1 1", overflow, drop_count);
    end
    tick();
    vectors++;
    if (overflow !== 1'b0) begin
      miscompares++;
      $display("FAIL ovf_width: overflow=%b one cycle later, required 0", overflow);
    end
    write_range(0, 63, 16'h24, -1);
    read_addr(10);
    vectors++;
    if (drop_count !== 16'd2 || dout_x !== 16'sh0021 || dout_lamb !== 16'sd10) begin
      miscompares++;
      $display("FAIL ovf_keepA: drop=%0d x=%h lamb=%0d, required 2 0021 10", drop_count, dout_x, dout_lamb);
    end
    pulse_done();
    read_addr(10);
    vectors++;
    if (dout_x !== 16'sh0022) begin
      miscompares++;
      $display("FAIL ovf_frameB: x=%h, required 0022", dout_x);
    end
    write_range(0, 63, 16'h25, -1);
  endtask

  task automatic test_release_same_cycle();
    write_range(0, 62, 16'h26, -1);
    lamb1 = 16'sd63; lamb2 = 16'sd0; eigen1_y = 16'sd163; eigen2_y = 16'sd0; eigen_x = 16'sh0026;
    din_valid = 1'b1;
    read_done = 1'b1;
    tick();
    din_valid = 1'b0;
    read_done = 1'b0;
    vectors++;
    if (overflow !== 1'b0 || drop_count !== 16'd2 || frame_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL same_cycle: overflow=%b drop=%0d ready=%b, required 0 2 1", overflow, drop_count, frame_ready);
    end
    read_addr(5);
    vectors++;
    if (dout_x !== 16'sh0025) begin
      miscompares++;
      $display("FAIL same_cycle_E: x=%h, required 0025", dout_x);
    end
    pulse_done();
    read_addr(63);
    vectors++;
    if (frame_ready !== 1'b1 || dout_x !== 16'sh0026 || dout_lamb !== 16'sd63) begin
      miscompares++;
      $display("FAIL same_cycle_new: ready=%b x=%h lamb=%0d, required 1 0026 63", frame_ready, dout_x, dout_lamb);
    end
    pulse_done();
  endtask

  task automatic test_error_and_reset();
    write_range(0, 63, 16'h31, 17);
    vectors++;
    if (frame_ready !== 1'b1 || frame_error !== 1'b1) begin
      miscompares++;
      $display("FAIL err_flag: ready=%b err=%b, required 1 1", frame_ready, frame_error);
    end
    pulse_done();
    write_range(0, 63, 16'h32, -1);
    vectors++;
    if (frame_ready !== 1'b1 || frame_error !== 1'b0) begin
      miscompares++;
      $display("FAIL err_clean: ready=%b err=%b, required 1 0", frame_ready, frame_error);
    end
    write_range(0, 29, 16'h40, -1);
    din_valid = 1'b1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    din_valid = 1'b0;
    vectors++;
    if (frame_ready !== 1'b0 || frame_error !== 1'b0 || drop_count !== 16'd0) begin
      miscompares++;
      $display("FAIL mid_reset: ready=%b err=%b drop=%0d, required 0 0 0", frame_ready, frame_error, drop_count);
    end
    write_range(0, 33, 16'h33, -1);
    vectors++;
    if (frame_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL addr_restart: ready=%b after 34 writes, required 0", frame_ready);
    end
    write_range(34, 63, 16'h33, -1);
    read_addr(40);
    vectors++;
    if (frame_ready !== 1'b1 || dout_lamb !== 16'sd40 || dout_x !== 16'sh0033) begin
      miscompares++;
      $display("FAIL post_reset_frame: ready=%b lamb=%0d x=%h, required 1 40 0033", frame_ready, dout_lamb, dout_x);
    end
  endtask

  initial begin
    rst = 1'b1;
    lamb1 = '0; lamb2 = '0; eigen1_y = '0; eigen2_y = '0; eigen_x = '0;
    din_valid = 1'b0; din_error = 1'b0;
    rd_addr = '0; rd_en = 1'b0; read_done = 1'b0;
    test_reset();
    test_basic_frame();
    test_dominant();
    test_back_to_back();
    test_overflow();
    test_release_same_cycle();
    test_error_and_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
